// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction fetch stage of the multi-cycle core, sitting directly in front
// of decode_stage. It owns the program counter and issues one request per
// instruction on the instruction-memory req/gnt/rvalid interface. The returned
// word is held in an instruction register and presented to decode until the
// core acknowledges it. The next PC is then PC+4 or a resolved branch/jump
// target. A flush restarts fetching at RESET_PC from any state.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds fetch_count_o, a free-running count of acknowledged
//   instructions. It is cleared only by reset and wraps at 2^32.
//
// Ports
//   clk_i            in   clock, rising edge
//   rst_i            in   asynchronous active-high reset
//   mem_req_o        out  fetch request valid
//   mem_addr_o       out  fetch byte address (current PC while requesting)
//   mem_gnt_i        in   memory accepts the request this cycle
//   mem_rvalid_i     in   response word valid
//   mem_rdata_i      in   response instruction word
//   instr_valid_o    out  instruction_o / pc_o hold a valid instruction
//   instruction_o    out  instruction register contents for decode
//   pc_o             out  PC of instruction_o
//   instr_ack_i      in   core finished the held instruction; fetch the next
//   branch_taken_i   in   qualified by instr_ack_i: next PC is branch_target_i
//   branch_target_i  in   redirect target (bits [1:0] ignored)
//   flush_i          in   discard in-flight work, restart at RESET_PC
//   fetch_count_o    out  acknowledged-instruction count (FETCH_PERF_CNT_EN only)
// ============================================================================

package params_pkg;
    parameter int INSTR_WIDTH = 32;
    typedef logic [INSTR_WIDTH-1:0] instruction_t;
endpackage

module fetch_stage
    import params_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
    output logic                   instr_valid_o,
    output instruction_t           instruction_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    input  logic                   instr_ack_i,
    input  logic                   branch_taken_i,
    input  logic [ADDR_WIDTH-1:0]  branch_target_i,
    input  logic                   flush_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count_o
`endif
);

    // Request the word, wait for its response, hold it for decode.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_next;
    instruction_t            ir;
    instruction_t            ir_next;
    logic                    kill;
    logic                    kill_next;
    logic [ADDR_WIDTH-1:0]   target_aligned;
    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic                    ack_accepted;

    // Redirect targets are always word aligned. The low two bits are
    // cleared here, so a misaligned target from execute cannot leak into the PC.
    assign target_aligned = branch_target_i & ~ADDR_WIDTH'(3);

    // Sequential increment wraps naturally at 2^ADDR_WIDTH.
    assign pc_plus4 = pc + ADDR_WIDTH'(4);

    // An acknowledge only counts when it is not overridden by a flush.
    assign ack_accepted = (state == S_HOLD) && instr_ack_i && !flush_i;

    // State register together with the datapath registers it governs.
    // Asserting reset mid-transaction abandons any outstanding response. The
    // memory side is expected to be reset alongside, so nothing is drained.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            ir    <= '0;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            kill  <= kill_next;
        end
    end

    // Next-state and datapath update logic.
    // The kill flag marks a response that is still owed by memory but belongs
    // to work discarded by a flush. The response has to be drained before the
    // next request, so a flushed WAIT stays put until rvalid and then drops
    // the word. A flush overrides any PC update chosen by the state decode,
    // including an acknowledge with a taken branch in the same cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        kill_next  = kill;

        case (state)
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_next = S_WAIT;
                    kill_next  = flush_i;
                end
            end

            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if (kill || flush_i) begin
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        ir_next    = mem_rdata_i;
                        state_next = S_HOLD;
                    end
                end else if (flush_i) begin
                    kill_next = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush_i) begin
                    state_next = S_REQ;
                end else if (instr_ack_i) begin
                    state_next = S_REQ;
                    pc_next    = branch_taken_i ? target_aligned : pc_plus4;
                end
            end

            default: begin
                state_next = S_REQ;
                kill_next  = 1'b0;
            end
        endcase

        if (flush_i) begin
            pc_next = RESET_PC;
        end
    end

    // Output decode from registered state only.
    // All outputs are forced low while reset is held. Otherwise the REQ
    // reset state would assert a request before reset is released.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        instr_valid_o = 1'b0;
        instruction_o = '0;
        pc_o          = '0;

        if (!rst_i) begin
            case (state)
                S_REQ: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = pc;
                end
                S_HOLD: begin
                    instr_valid_o = 1'b1;
                    instruction_o = ir;
                    pc_o          = pc;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;

    // Count of acknowledged instructions. A flush does not clear this counter,
    // and an acknowledge cancelled by a flush is not counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_count <= '0;
        end else if (ack_accepted) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign fetch_count_o = fetch_count;
`else
    logic unused_ack;

    // Without the counter, the qualified acknowledge has no consumer.
    assign unused_ack = ack_accepted;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
// ----------------------------------------------------------------------------
// Self-checking bench for fetch_stage. A table of fetch transactions is run by
// applyStimulus. Each transaction lists its memory timing, the acknowledge
// behaviour and the expected addresses. Expected {pc, instruction} pairs go
// into a scoreboard queue when the memory grants a request. They are popped
// when the DUT presents an instruction. Hand-written sequences cover flush
// and reset corner cases. Build with +define+FETCH_PERF_CNT_EN to also check
// the fetch counter.
// ============================================================================

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int exp_count = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int          gnt_wait;
        int          rv_wait;
        int          ack_wait;
        bit          taken;
        logic [31:0] target;
        bit          flush;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic [31:0] exp_next;
        bit          chk_lat;
    } vec_t;

    vec_t vecs[13];

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_gnt_i       (mem_gnt),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .instr_valid_o   (instr_valid),
        .instruction_o   (instruction),
        .pc_o            (pc),
        .instr_ack_i     (instr_ack),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .flush_i         (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input int gw, input int rw, input int aw,
                                input bit tk, input logic [31:0] tg, input bit fl,
                                input logic [31:0] ea, input logic [31:0] rd,
                                input logic [31:0] en, input bit lat);
        vec_t v;
        v.gnt_wait = gw;
        v.rv_wait  = rw;
        v.ack_wait = aw;
        v.taken    = tk;
        v.target   = tg;
        v.flush    = fl;
        v.exp_addr = ea;
        v.rdata    = rd;
        v.exp_next = en;
        v.chk_lat  = lat;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkCount();
`ifdef FETCH_PERF_CNT_EN
        checkOutput("fetch_count", fetch_count, exp_count);
`endif
    endtask

    task automatic clearInputs();
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = $urandom;
        instr_ack     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        flush         = 1'b0;
    endtask

    // One complete fetch: request (optionally stalled), response, hold, ack.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        checkOutput("req_on_entry", mem_req, 1);
        checkOutput("req_addr", mem_addr, v.exp_addr);
        for (int i = 0; i < v.gnt_wait; i++) begin
            mem_gnt = 1'b0;
            step();
            checkOutput("req_held", mem_req, 1);
            checkOutput("addr_stable", mem_addr, v.exp_addr);
        end
        mem_gnt = 1'b1;
        e.addr  = v.exp_addr;
        e.instr = v.rdata;
        sb.push_back(e);
        step();
        mem_gnt = 1'b0;
        checkOutput("req_drop_after_gnt", mem_req, 0);
        for (int i = 1; i < v.rv_wait; i++) begin
            step();
            checkOutput("valid_low_in_wait", instr_valid, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        checkOutput("instr_valid", instr_valid, 1);
        if (v.chk_lat) begin
            checkOutput("ack_to_valid_cycles", 32'(cyc - ack_cyc), 3);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_pop: got empty scoreboard, expected an entry");
        end else begin
            e = sb.pop_front();
            checkOutput("pc_o", pc, e.addr);
            checkOutput("instruction_o", instruction, e.instr);
        end
        // Without ack, branch inputs and stray rvalid must be ignored.
        for (int i = 0; i < v.ack_wait; i++) begin
            branch_taken  = 1'b1;
            branch_target = $urandom;
            mem_rvalid    = 1'b1;
            mem_rdata     = $urandom;
            step();
            clearInputs();
            checkOutput("hold_valid", instr_valid, 1);
            checkOutput("hold_instr", instruction, e.instr);
            checkOutput("hold_pc", pc, e.addr);
        end
        instr_ack     = 1'b1;
        branch_taken  = v.taken;
        branch_target = v.target;
        flush         = v.flush;
        ack_cyc       = cyc;
        if (!v.flush) exp_count++;
        step();
        clearInputs();
        checkOutput("next_req_latency", mem_req, 1);
        checkOutput("valid_drop_after_ack", instr_valid, 0);
        checkOutput("next_addr", mem_addr, v.exp_next);
        checkCount();
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();

        //           gw rw aw tk target        fl addr          rdata          next          lat
        vecs[0]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0013, 32'h4,        0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h4,        32'h0010_0093, 32'h8,        1);
        vecs[2]  = mk(5, 1, 0, 0, 32'h0,        0, 32'h8,        32'h0020_0113, 32'hC,        0);
        vecs[3]  = mk(0, 3, 2, 0, 32'h0,        0, 32'hC,        32'h0030_0193, 32'h10,       0);
        vecs[4]  = mk(0, 1, 0, 1, 32'h47,       0, 32'h10,       32'h0340_006F, 32'h44,       1);
        vecs[5]  = mk(0, 1, 0, 1, 32'hFFFF_FFFF,0, 32'h44,       32'hFE00_0EE3, 32'hFFFF_FFFC, 1);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0000_0073, 32'h0,       1);
        vecs[7]  = mk(0, 1, 0, 1, 32'h100,      1, 32'h0,        32'h1111_1111, 32'h0,        1);
        vecs[8]  = mk(0, 1, 0, 1, 32'h20,       0, 32'h0,        32'h2222_2222, 32'h20,       1);
        vecs[9]  = mk(0, 1, 0, 1, 32'h30,       0, 32'h0,        32'h3333_3333, 32'h30,       0);
        vecs[10] = mk(0, 1, 0, 1, 32'h42,       0, 32'h0,        32'h4444_4444, 32'h40,       0);
        vecs[11] = mk(0, 2, 0, 0, 32'h0,        0, 32'h0,        32'h5555_5555, 32'h4,        0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h6666_6666, 32'h4,        0);

        // Reset: every output low while reset is held.
        step();
        step();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_instr_valid", instr_valid, 0);
        checkOutput("rst_instruction", instruction, 0);
        checkOutput("rst_pc", pc, 0);
        checkCount();
        rst = 1'b0;
        #1;

        // Table-driven fetches: sequential, stalled grant, branches, wrap, flush+ack.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Flush in WAIT at 'h20; late response must be dropped.
        checkOutput("A_addr", mem_addr, 32'h20);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("A_drain_no_req", mem_req, 0);
            checkOutput("A_drain_no_valid", instr_valid, 0);
            step();
        end
        checkOutput("A_drain_no_req", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        clearInputs();
        checkOutput("A_valid_after_drop", instr_valid, 0);
        checkOutput("A_req_after_drop", mem_req, 1);
        checkOutput("A_addr_after_drop", mem_addr, 32'h0);
        step();
        checkOutput("A_valid_later", instr_valid, 0);

        applyStimulus(vecs[9]);

        // Flush together with grant in REQ: the response is owed but discarded.
        checkOutput("C_addr", mem_addr, 32'h30);
        mem_gnt = 1'b1;
        flush   = 1'b1;
        step();
        clearInputs();
        checkOutput("C_wait_no_req", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        clearInputs();
        checkOutput("C_valid_after_drop", instr_valid, 0);
        checkOutput("C_addr_after_drop", mem_addr, 32'h0);

        applyStimulus(vecs[10]);

        // Flush in REQ without grant: restart immediately at RESET_PC.
        checkOutput("D_addr", mem_addr, 32'h40);
        flush = 1'b1;
        step();
        clearInputs();
        checkOutput("D_req", mem_req, 1);
        checkOutput("D_addr_after", mem_addr, 32'h0);

        applyStimulus(vecs[11]);

        // Flush coinciding with rvalid in WAIT: word dropped.
        mem_gnt = 1'b1;
        step();
        clearInputs();
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        step();
        clearInputs();
        checkOutput("E_valid", instr_valid, 0);
        checkOutput("E_req", mem_req, 1);
        checkOutput("E_addr", mem_addr, 32'h0);
        checkCount();

        // Reset asserted asynchronously mid-transaction in WAIT.
        mem_gnt = 1'b1;
        step();
        clearInputs();
        #2;
        rst = 1'b1;
        #1;
        exp_count = 0;
        checkOutput("F_rst_req", mem_req, 0);
        checkOutput("F_rst_valid", instr_valid, 0);
        checkOutput("F_rst_addr", mem_addr, 0);
        checkCount();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("F_req_after_rst", mem_req, 1);
        checkOutput("F_addr_after_rst", mem_addr, 32'h0);
        checkOutput("F_valid_after_rst", instr_valid, 0);

        applyStimulus(vecs[12]);

        checkOutput("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
